// File: rtl/data_input_ctrl.sv
// data_input_ctrl: deserialises framed MSB-first words and emits one memory
// write per completed word into a circular buffer addressed by a wrapping pointer.
module data_input_ctrl #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              Sclk,
   input  logic              Reset_n,
   input  logic              Frame,
   input  logic              InputL,
   input  logic              enable,
   input  logic              clear_ptr,
   output logic [WORD_W-1:0] in_data,
   output logic              in_flag,
   output logic              write_enable,
   output logic [ADDR_W-1:0] datawrite,
   output logic              frame_err
);
   localparam int CW = $clog2(WORD_W);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WORD_W - 2);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-1:0] sr_q, sr_d, data_q, data_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              flag_q, flag_d, ferr_q, ferr_d;
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         ptr_q   <= '0;
         flag_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         ptr_q   <= ptr_d;
         flag_q  <= flag_d;
         ferr_q  <= ferr_d;
      end
   end
   // The pointer advances on the edge closing the write cycle; clear wins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      data_d  = data_q;
      flag_d  = 1'b0;
      ferr_d  = 1'b0;
      ptr_d   = clear_ptr ? '0 : ptr_q + ADDR_W'(flag_q);
      if (state_q == IDLE) begin
         if (Frame && enable) begin
            state_d = SHIFT;
            cnt_d   = CNT_LOAD;
            sr_d    = {{(WORD_W-1){1'b0}}, InputL};
         end
      end else if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (Frame && cnt_q != '0) begin
         ferr_d = 1'b1;
         cnt_d  = CNT_LOAD;
         sr_d   = {{(WORD_W-1){1'b0}}, InputL};
      end else begin
         sr_d  = {sr_q[WORD_W-2:0], InputL};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            data_d  = {sr_q[WORD_W-2:0], InputL};
            flag_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
      end
   end
   assign in_data      = data_q;
   assign in_flag      = flag_q;
   assign write_enable = flag_q;
   assign datawrite    = ptr_q;
   assign frame_err    = ferr_q;
endmodule

// File: tb/tb_data_input_ctrl.sv
// tb_data_input_ctrl: directed bench for data_input_ctrl; expected writes are
// queued as {address, data} when a word is sent and popped at each write strobe.
module tb_data_input_ctrl;
   logic        Sclk = 1'b0, Reset_n = 1'b0, Frame = 1'b0, InputL = 1'b0, enable = 1'b0, clear_ptr = 1'b0;
   logic [15:0] in_data;
   logic [7:0]  datawrite;
   logic        in_flag, write_enable, frame_err;
   int          total = 0, bad = 0, nflag = 0, nferr = 0, n0, f0;
   logic        prev_we = 1'b0, prev_fe = 1'b0;
   logic [7:0]  exp_ptr = 8'd0, p0;
   logic [23:0] sb[$];

   always #5 Sclk = ~Sclk;

   data_input_ctrl dut (
      .Sclk(Sclk), .Reset_n(Reset_n), .Frame(Frame), .InputL(InputL), .enable(enable),
      .clear_ptr(clear_ptr), .in_data(in_data), .in_flag(in_flag), .write_enable(write_enable),
      .datawrite(datawrite), .frame_err(frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one bit, let the rising edge sample it, then inspect outputs on the falling edge.
   task automatic step(input logic f, input logic b, input logic en = 1'b1, input logic clr = 1'b0);
      logic [23:0] e;
      Frame = f; InputL = b; enable = en; clear_ptr = clr;
      @(negedge Sclk);
      chk("flag_eq_we", 32'(in_flag), 32'(write_enable));
      chk("we_single", 32'(write_enable & prev_we), 32'd0);
      chk("ferr_single", 32'(frame_err & prev_fe), 32'd0);
      if (write_enable) begin
         nflag++;
         chk("write_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("data", 32'(in_data), 32'(e[15:0]));
            chk("addr", 32'(datawrite), 32'(e[23:16]));
         end
      end
      if (frame_err) nferr++;
      prev_we = write_enable;
      prev_fe = frame_err;
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits = 16, input logic push = 1'b1);
      if (push) begin
         sb.push_back({exp_ptr, w});
         exp_ptr++;
      end
      for (int i = 0; i < nbits; i++) step(i == 0, w[15-i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in_data"}, 32'(in_data), 32'd0);
      chk({tag, "_in_flag"}, 32'(in_flag), 32'd0);
      chk({tag, "_we"}, 32'(write_enable), 32'd0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
      chk({tag, "_addr"}, 32'(datawrite), 32'd0);
   endtask

   initial begin
      #1 chk_zero("reset");
      @(negedge Sclk);
      Reset_n = 1'b1;
      idle(2);
      // single word 0xA5C3 at address 0
      send_word(16'hA5C3);
      step(1'b0, 1'b0);
      chk("a5c3_flag_off", 32'(in_flag), 32'd0);
      chk("a5c3_ptr", 32'(datawrite), 32'd1);
      chk("a5c3_nflag", 32'(nflag), 32'd1);
      chk("a5c3_hold", 32'(in_data), 32'hA5C3);
      // 300 back-to-back words, pointer wraps
      step(1'b0, 1'b0, 1'b1, 1'b1);
      exp_ptr = 8'd0;
      chk("clr_ptr", 32'(datawrite), 32'd0);
      n0 = nflag; f0 = nferr;
      for (int w = 1; w <= 300; w++) send_word(16'(w));
      idle(2);
      chk("b2b_flags", 32'(nflag - n0), 32'd300);
      chk("b2b_ferr", 32'(nferr - f0), 32'd0);
      chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
      chk("b2b_ptr", 32'(datawrite), 32'd44);
      // abort at bit 7, then clean 0x1234
      n0 = nflag; f0 = nferr;
      send_word(16'hBEEF, 8, 1'b0);
      send_word(16'h1234);
      idle(2);
      chk("abort_ferr", 32'(nferr - f0), 32'd1);
      chk("abort_flags", 32'(nflag - n0), 32'd1);
      chk("abort_sb_empty", 32'(sb.size()), 32'd0);
      chk("abort_ptr", 32'(datawrite), 32'd45);
      // clear_ptr during the write cycle at address 9
      step(1'b0, 1'b0, 1'b1, 1'b1);
      exp_ptr = 8'd0;
      for (int i = 0; i < 9; i++) send_word(16'($urandom));
      send_word(16'h0909);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      exp_ptr = 8'd0;
      chk("clr9_ptr", 32'(datawrite), 32'd0);
      send_word(16'h5A5A);
      idle(1);
      chk("clr9_sb_empty", 32'(sb.size()), 32'd0);
      chk("clr9_ptr_after", 32'(datawrite), 32'd1);
      // asynchronous reset mid-word
      send_word(16'h7777, 5, 1'b0);
      #2 Reset_n = 1'b0;
      #1 chk_zero("async_rst");
      #1 Reset_n = 1'b1;
      exp_ptr = 8'd0;
      send_word(16'hFFFF);
      idle(1);
      chk("rst_sb_empty", 32'(sb.size()), 32'd0);
      // enable low: partial word dropped, toggling Frame ignored
      n0 = nflag; f0 = nferr; p0 = datawrite;
      send_word(16'h3C3C, 6, 1'b0);
      for (int i = 0; i < 40; i++) step(1'($urandom), 1'($urandom), 1'b0);
      idle(2);
      chk("dis_flags", 32'(nflag - n0), 32'd0);
      chk("dis_ferr", 32'(nferr - f0), 32'd0);
      chk("dis_ptr", 32'(datawrite), 32'(p0));
      chk("dis_ptr_val", 32'(datawrite), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
